// File: rtl/mc_control_fsm_if.sv
// Memory-port bundle between the multi-cycle control unit and the shared
// instruction/data memory.
//   mem_read  : read strobe (instruction fetch or lw data read)
//   mem_write : write strobe (sw)
//   iord      : address select, 0 = PC, 1 = ALUOut
//   mem_ready : memory has completed the current access
// master = control unit, slave = memory.
interface mc_control_fsm_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_read, mem_write, iord, input mem_ready);
  modport slave  (input mem_read, mem_write, iord, output mem_ready);
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit. Sequences each instruction through
// FETCH/DECODE/EXEC/MEM_RD/MEM_WR/WB/BRANCH/JUMP and drives the datapath
// muxes and write enables combinationally from state, IR fields and the
// handshake inputs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem                 memory port (mem_read, mem_write, iord, mem_ready)
//   opcode, funct       IR[31:26], IR[5:0]
//   branch_taken        branch condition from the datapath
//   ir_write, pc_write  IR / PC load enables
//   pc_src              00 PC+4, 01 branch target, 10 jump, 11 rs
//   reg_write, reg_dst, reg_write_src   register-file write controls
//   alu_src_a, alu_src_b, alu_op        ALU operand/operation selects
//   sign_extend         immediate extension mode
//   state               current FSM state (debug)
//   mem_timeout, illegal_op  single-cycle error pulses
module mc_control_fsm #(
  parameter int MEM_TIMEOUT  = 255,
  parameter bit ENABLE_CRYPT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  mc_control_fsm_if.master    mem,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                branch_taken,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          reg_write_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [3:0]          alu_op,
  output logic                sign_extend,
  output logic [2:0]          state,
  output logic                mem_timeout,
  output logic                illegal_op
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6,
    JUMP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02,
                         OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE  = 6'h05,
                         OP_ADDI  = 6'h08, OP_SLTI   = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI   = 6'h0E, OP_LUI  = 6'h0F,
                         OP_CRYPT = 6'h1C, OP_LW     = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_FUNCT = 4'd2,
                         ALU_AND = 4'd3, ALU_OR  = 4'd4, ALU_XOR   = 4'd5,
                         ALU_SLT = 4'd6, ALU_LUI = 4'd7;

  // A zero limit disables the timeout; keep the counter at least one bit wide.
  localparam int            CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  state_t        cur_state, nxt;
  logic [CW-1:0] cnt;
  logic          limit_hit;

  logic is_rtype, is_jreg, is_ialu, is_lw, is_sw, is_crypt, is_branch, is_jump;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jreg   = is_rtype && (funct == FN_JR || funct == FN_JALR);
  assign is_ialu   = opcode inside {OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_crypt  = ENABLE_CRYPT && (opcode == OP_CRYPT);
  assign is_branch = opcode inside {OP_REGIMM, OP_BEQ, OP_BNE};
  assign is_jump   = opcode inside {OP_J, OP_JAL};

  // mem_ready arriving on the limit cycle completes the access instead.
  assign limit_hit = (MEM_TIMEOUT != 0) && !mem.mem_ready && (cnt == LIMIT);

  always_comb begin
    // NOTE: every output and nxt gets a default first, so no path through
    // the case below can infer a latch.
    nxt           = cur_state;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    mem.iord      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    reg_write_src = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALU_ADD;
    sign_extend   = 1'b0;
    mem_timeout   = 1'b0;
    illegal_op    = 1'b0;

    // Outputs stay at their zero defaults for as long as reset is asserted.
    if (rst_n) begin
      sign_extend = opcode inside {OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_REGIMM};
      unique case (cur_state)
        FETCH: begin
          mem.mem_read = 1'b1;
          if (mem.mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            nxt       = DECODE;
          end else if (limit_hit) begin
            mem_timeout = 1'b1;
          end
        end
        DECODE: begin
          // Precompute the branch target into ALUOut.
          alu_src_b = 2'b11;
          if (is_jump || is_jreg)                                  nxt = JUMP;
          else if (is_branch)                                      nxt = BRANCH;
          else if (is_rtype || is_ialu || is_lw || is_sw || is_crypt) nxt = EXEC;
          else begin
            illegal_op = 1'b1;
            nxt        = FETCH;
          end
        end
        EXEC: begin
          alu_src_a = 1'b1;
          if (is_rtype || is_crypt) begin
            alu_op = ALU_FUNCT;
          end else begin
            alu_src_b = 2'b10;
            case (opcode)
              OP_SLTI: alu_op = ALU_SLT;
              OP_ANDI: alu_op = ALU_AND;
              OP_ORI:  alu_op = ALU_OR;
              OP_XORI: alu_op = ALU_XOR;
              OP_LUI:  alu_op = ALU_LUI;
              default: alu_op = ALU_ADD;
            endcase
          end
          nxt = is_lw ? MEM_RD : (is_sw ? MEM_WR : WB);
        end
        MEM_RD: begin
          mem.mem_read = 1'b1;
          mem.iord     = 1'b1;
          if (mem.mem_ready) nxt = WB;
          else if (limit_hit) begin
            mem_timeout = 1'b1;
            nxt         = FETCH;
          end
        end
        MEM_WR: begin
          mem.mem_write = 1'b1;
          mem.iord      = 1'b1;
          if (mem.mem_ready) nxt = FETCH;
          else if (limit_hit) begin
            mem_timeout = 1'b1;
            nxt         = FETCH;
          end
        end
        WB: begin
          reg_write = 1'b1;
          if (is_lw)         reg_write_src = 2'b01;
          else if (is_crypt) begin reg_dst = 2'b01; reg_write_src = 2'b11; end
          else if (is_rtype) reg_dst = 2'b01;
          nxt = FETCH;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_src    = 2'b01;
          pc_write  = branch_taken;
          nxt       = FETCH;
        end
        JUMP: begin
          pc_write = 1'b1;
          if (is_jreg) begin
            pc_src = 2'b11;
            if (funct == FN_JALR) begin
              reg_write = 1'b1; reg_dst = 2'b01; reg_write_src = 2'b10;
            end
          end else begin
            pc_src = 2'b10;
            if (opcode == OP_JAL) begin
              reg_write = 1'b1; reg_dst = 2'b10; reg_write_src = 2'b10;
            end
          end
          nxt = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      cnt       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values computed by the combinational block.
      cur_state <= nxt;
      if (nxt != cur_state || mem_timeout)
        cnt <= '0;
      else if (!mem.mem_ready && cur_state inside {FETCH, MEM_RD, MEM_WR})
        cnt <= cnt + CW'(1);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Two instances: dut_a (timeout 4,
// crypt enabled) and dut_b (timeout disabled, crypt disabled); only one is
// out of reset at a time and the selected one is compared each cycle against
// an instruction-level model that expands each instruction into its expected
// sequence of phases and derives the control outputs of each phase.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, reg_write_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       sign_extend, mem_timeout, illegal_op;
  } ctl_t;

  typedef struct { int st; bit rdy; bit tmo; } step_t;
  typedef enum { C_R, C_JR, C_JALR, C_IALU, C_LW, C_SW, C_CRYPT, C_BR, C_J, C_JAL, C_ILL } cls_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n, sel, rdy, branch_taken;
  logic [5:0] opcode, funct;
  int         checks = 0, errors = 0, limit = 4;
  bit         crypt_en = 1'b1;
  step_t      plan[$];

  mc_control_fsm_if bus_a ();
  mc_control_fsm_if bus_b ();
  assign bus_a.mem_ready = rdy;
  assign bus_b.mem_ready = rdy;

  logic       a_ir_write, a_pc_write, a_reg_write, a_alu_src_a, a_sign_extend, a_mem_timeout, a_illegal_op;
  logic [1:0] a_pc_src, a_reg_dst, a_reg_write_src, a_alu_src_b;
  logic [3:0] a_alu_op;
  logic [2:0] a_state;
  logic       b_ir_write, b_pc_write, b_reg_write, b_alu_src_a, b_sign_extend, b_mem_timeout, b_illegal_op;
  logic [1:0] b_pc_src, b_reg_dst, b_reg_write_src, b_alu_src_b;
  logic [3:0] b_alu_op;
  logic [2:0] b_state;

  mc_control_fsm #(.MEM_TIMEOUT(4), .ENABLE_CRYPT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .mem(bus_a.master), .opcode(opcode), .funct(funct),
    .branch_taken(branch_taken), .ir_write(a_ir_write), .pc_write(a_pc_write),
    .pc_src(a_pc_src), .reg_write(a_reg_write), .reg_dst(a_reg_dst),
    .reg_write_src(a_reg_write_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
    .alu_op(a_alu_op), .sign_extend(a_sign_extend), .state(a_state),
    .mem_timeout(a_mem_timeout), .illegal_op(a_illegal_op));

  mc_control_fsm #(.MEM_TIMEOUT(0), .ENABLE_CRYPT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .mem(bus_b.master), .opcode(opcode), .funct(funct),
    .branch_taken(branch_taken), .ir_write(b_ir_write), .pc_write(b_pc_write),
    .pc_src(b_pc_src), .reg_write(b_reg_write), .reg_dst(b_reg_dst),
    .reg_write_src(b_reg_write_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b),
    .alu_op(b_alu_op), .sign_extend(b_sign_extend), .state(b_state),
    .mem_timeout(b_mem_timeout), .illegal_op(b_illegal_op));

  ctl_t out_a, out_b, act;
  assign out_a = {a_state, bus_a.mem_read, bus_a.mem_write, bus_a.iord, a_ir_write, a_pc_write,
                  a_pc_src, a_reg_write, a_reg_dst, a_reg_write_src, a_alu_src_a, a_alu_src_b,
                  a_alu_op, a_sign_extend, a_mem_timeout, a_illegal_op};
  assign out_b = {b_state, bus_b.mem_read, bus_b.mem_write, bus_b.iord, b_ir_write, b_pc_write,
                  b_pc_src, b_reg_write, b_reg_dst, b_reg_write_src, b_alu_src_a, b_alu_src_b,
                  b_alu_op, b_sign_extend, b_mem_timeout, b_illegal_op};
  assign act = sel ? out_b : out_a;

  logic [5:0] op_tab [16] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                              6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h1C, 6'h23, 6'h2B};

  task automatic check(input ctl_t a, input ctl_t e, input string tag);
    checks++;
    assert (a === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, a, e);
    end
  endtask

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: return (fn == 6'h08) ? C_JR : ((fn == 6'h09) ? C_JALR : C_R);
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return C_IALU;
      6'h23: return C_LW;
      6'h2B: return C_SW;
      6'h1C: return crypt_en ? C_CRYPT : C_ILL;
      6'h01, 6'h04, 6'h05: return C_BR;
      6'h02: return C_J;
      6'h03: return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  // Appends a memory phase with `waits` not-ready cycles; returns 1 if the
  // access is aborted by the timeout (which ends the instruction).
  function automatic bit mem_phase(input int st, input int waits);
    for (int i = 0; i < waits; i++) begin
      if (limit != 0 && i == limit) begin
        plan.push_back('{st, 1'b0, 1'b1});
        return 1'b1;
      end
      plan.push_back('{st, 1'b0, 1'b0});
    end
    plan.push_back('{st, 1'b1, 1'b0});
    return 1'b0;
  endfunction

  function automatic ctl_t exp_out(input step_t s, input logic [5:0] op, input logic [5:0] fn,
                                   input logic bt, input cls_t c);
    ctl_t e = '0;
    e.state = 3'(s.st);
    case (s.st)
      0: begin
        e.mem_read = 1'b1; e.mem_timeout = s.tmo;
        if (s.rdy) begin e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'b01; end
      end
      1: begin e.alu_src_b = 2'b11; e.illegal_op = (c == C_ILL); end
      2: begin
        e.alu_src_a = 1'b1;
        if (c == C_R || c == C_CRYPT) e.alu_op = 4'd2;
        else begin
          e.alu_src_b = 2'b10;
          case (op)
            6'h0A: e.alu_op = 4'd6;
            6'h0C: e.alu_op = 4'd3;
            6'h0D: e.alu_op = 4'd4;
            6'h0E: e.alu_op = 4'd5;
            6'h0F: e.alu_op = 4'd7;
            default: e.alu_op = 4'd0;
          endcase
        end
      end
      3: begin e.mem_read = 1'b1; e.iord = 1'b1; e.mem_timeout = s.tmo; end
      4: begin e.mem_write = 1'b1; e.iord = 1'b1; e.mem_timeout = s.tmo; end
      5: begin
        e.reg_write = 1'b1;
        if (c == C_R)          e.reg_dst = 2'b01;
        else if (c == C_LW)    e.reg_write_src = 2'b01;
        else if (c == C_CRYPT) begin e.reg_dst = 2'b01; e.reg_write_src = 2'b11; end
      end
      6: begin e.alu_src_a = 1'b1; e.alu_op = 4'd1; e.pc_src = 2'b01; e.pc_write = bt; end
      default: begin
        e.pc_write = 1'b1;
        e.pc_src = (c == C_JR || c == C_JALR) ? 2'b11 : 2'b10;
        if (c == C_JAL)  begin e.reg_write = 1'b1; e.reg_dst = 2'b10; e.reg_write_src = 2'b10; end
        if (c == C_JALR) begin e.reg_write = 1'b1; e.reg_dst = 2'b01; e.reg_write_src = 2'b10; end
      end
    endcase
    if (s.st != 0)
      e.sign_extend = op inside {6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h01};
    if (fn == 6'h3F && 1'b0) e.state = 3'd0;  // funct only matters through the class
    return e;
  endfunction

  // Runs one instruction: wf/wm are not-ready cycles in the fetch and data
  // memory phases. Expects the DUT in the first FETCH cycle at entry.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic bt,
                           input int wf, input int wm);
    cls_t c = classify(op, fn);
    ctl_t e, a;
    plan.delete();
    if (!mem_phase(0, wf)) begin
      plan.push_back('{1, 1'b0, 1'b0});
      case (c)
        C_BR:              plan.push_back('{6, 1'b0, 1'b0});
        C_J, C_JAL, C_JR, C_JALR: plan.push_back('{7, 1'b0, 1'b0});
        C_ILL: ;
        default: begin
          plan.push_back('{2, 1'b0, 1'b0});
          if (c == C_LW) begin
            if (!mem_phase(3, wm)) plan.push_back('{5, 1'b0, 1'b0});
          end else if (c == C_SW) begin
            void'(mem_phase(4, wm));
          end else plan.push_back('{5, 1'b0, 1'b0});
        end
      endcase
    end
    foreach (plan[i]) begin
      @(negedge clk);
      if (i == 0) begin opcode = op; funct = fn; branch_taken = bt; end
      rdy = (plan[i].st inside {0, 3, 4}) ? plan[i].rdy : 1'($urandom);
      #1;
      e = exp_out(plan[i], op, fn, bt, c);
      a = act;
      if (e.state == 3'd0) a.sign_extend = 1'b0;
      check(a, e, $sformatf("op%02h fn%02h step%0d", op, fn, i));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rop, rfn;
    int         rwf, rwm;
    ctl_t       e;

    rst_a_n = 1'b0; rst_b_n = 1'b0; sel = 1'b0; rdy = 1'b1;
    opcode = 6'h23; funct = 6'h00; branch_taken = 1'b1;
    #12;
    check(act, '0, "reset_a");
    sel = 1'b1; #1;
    check(act, '0, "reset_b");
    sel = 1'b0;
    @(posedge clk); #1 rst_a_n = 1'b1;

    // Directed instructions on dut_a.
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // add
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // lw, 3 wait states
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // jal
    run_instr(6'h02, 6'h00, 1'b0, 1, 0);   // j
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // jr
    run_instr(6'h00, 6'h09, 1'b0, 0, 0);   // jalr
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);   // illegal
    run_instr(6'h1C, 6'h11, 1'b0, 0, 0);   // crypt enabled
    for (int i = 7; i < 13; i++) run_instr(op_tab[i], 6'h00, 1'b0, 0, 0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 0);   // sw
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // bne
    run_instr(6'h01, 6'h00, 1'b1, 0, 0);   // regimm
    run_instr(6'h00, 6'h20, 1'b0, 6, 0);   // fetch timeout on 5th cycle
    run_instr(6'h00, 6'h22, 1'b0, 4, 0);   // ready on the limit cycle wins
    run_instr(6'h23, 6'h00, 1'b0, 0, 9);   // MEM_RD timeout
    run_instr(6'h2B, 6'h00, 1'b0, 0, 4);   // MEM_WR ready wins
    run_instr(6'h2B, 6'h00, 1'b0, 0, 5);   // MEM_WR timeout

    // Randomized instruction mix.
    for (int n = 0; n < 80; n++) begin
      rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 15)];
      rfn = ($urandom_range(0, 3) == 0) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom);
      rwf = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
      rwm = $urandom_range(0, 6);
      run_instr(rop, rfn, 1'($urandom), rwf, rwm);
    end

    // Reset asserted in the middle of a store.
    @(negedge clk); opcode = 6'h2B; funct = 6'h00; rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    e = exp_out('{4, 1'b0, 1'b0}, 6'h2B, 6'h00, 1'b0, C_SW);
    check(act, e, "sw_in_mem_wr");
    #2 rst_a_n = 1'b0;
    #1 check(act, '0, "reset_mid_mem_wr");
    @(posedge clk); #1 check(act, '0, "reset_held");
    @(posedge clk); #1 rst_a_n = 1'b1;
    run_instr(6'h00, 6'h25, 1'b0, 0, 0);
    run_instr(6'h0D, 6'h00, 1'b0, 2, 0);

    // Switch to dut_b: timeout disabled, crypt illegal.
    @(posedge clk); #1;
    rst_a_n = 1'b0; rst_b_n = 1'b1; sel = 1'b1; limit = 0; crypt_en = 1'b0;
    run_instr(6'h1C, 6'h00, 1'b0, 0, 0);
    run_instr(6'h00, 6'h20, 1'b0, 300, 0);
    run_instr(6'h23, 6'h00, 1'b0, 1, 7);
    run_instr(6'h2B, 6'h00, 1'b0, 0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
